// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch/decode/execute controller: FSM states,
// PC-select codes and instruction opcodes.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_BRANCH = 2'b10;
    localparam logic [1:0] PS_JUMP   = 2'b11;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BRZ  = 4'hA;
    localparam logic [3:0] OP_BRNZ = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/fetch_decode.sv
// Pure combinational opcode decoder; the caller gates its outputs so they
// only take effect during EXECUTE.
module fetch_decode
    import fetch_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       zero,
    output logic [1:0] ps,
    output logic       rw,
    output logic       mw,
    output logic [3:0] alu_op,
    output logic       illegal_op
);

    always_comb begin
        ps         = PS_INC;
        rw         = 1'b0;
        mw         = 1'b0;
        alu_op     = 4'h0;
        illegal_op = 1'b0;
        case (opcode)
            OP_NOP: ps = PS_INC;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                alu_op = opcode;
                rw     = 1'b1;
            end
            OP_LD:   rw = 1'b1;
            OP_ST:   mw = 1'b1;
            OP_BRZ:  ps = zero ? PS_BRANCH : PS_INC;
            OP_BRNZ: ps = zero ? PS_INC : PS_BRANCH;
            OP_JMP:  ps = PS_JUMP;
            OP_HALT: ps = PS_HOLD;
            // 0xD and 0xE fall through as a NOP that flags the fault
            default: illegal_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_control.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE, with a
// terminal HALT state and a sticky illegal-opcode flag.
module fetch_control
    import fetch_ctrl_pkg::*;
(
    input  logic        clk_main,
    input  logic        reset,
    input  logic [5:0]  PC,
    output logic [5:0]  instr_addr,
    input  logic [15:0] instr_data,
    input  logic        instr_valid,
    input  logic        zero,
    input  logic [15:0] reg_a_data,
    output logic [1:0]  PS,
    output logic [3:0]  SA,
    output logic [3:0]  SB,
    output logic [3:0]  DR,
    output logic [5:0]  A,
    output logic [3:0]  alu_op,
    output logic        RW,
    output logic        MW,
    output logic        halted,
    output logic        illegal
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;

    logic [1:0]  dec_ps;
    logic        dec_rw;
    logic        dec_mw;
    logic [3:0]  dec_alu;
    logic        dec_ill;

    // Jump targets are only 6 bits wide; the upper register bits are dropped.
    logic        unused_reg_a_hi;
    assign unused_reg_a_hi = ^reg_a_data[15:6];

    fetch_decode u_decode (
        .opcode     (ir_q[15:12]),
        .zero       (zero),
        .ps         (dec_ps),
        .rw         (dec_rw),
        .mw         (dec_mw),
        .alu_op     (dec_alu),
        .illegal_op (dec_ill)
    );

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= 16'h0000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        PS        = PS_HOLD;
        RW        = 1'b0;
        MW        = 1'b0;
        alu_op    = 4'h0;
        A         = 6'h00;
        halted    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                PS     = dec_ps;
                RW     = dec_rw;
                MW     = dec_mw;
                alu_op = dec_alu;
                if (ir_q[15:12] == OP_JMP)
                    A = reg_a_data[5:0];
                if (dec_ill)
                    illegal_d = 1'b1;
                state_d = (ir_q[15:12] == OP_HALT) ? ST_HALT : ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_FETCH;
        endcase
    end

    assign instr_addr = PC;
    assign DR         = ir_q[11:8];
    assign SA         = ir_q[7:4];
    assign SB         = ir_q[3:0];
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench: stimulus pushes a per-cycle expected output vector,
// an independent monitor pops and compares each one.
module tb_fetch_control;

    logic        clk_main = 1'b0;
    logic        reset    = 1'b0;
    logic [5:0]  PC;
    logic [5:0]  instr_addr;
    logic [15:0] instr_data;
    logic        instr_valid;
    logic        zero;
    logic [15:0] reg_a_data;
    logic [1:0]  PS;
    logic [3:0]  SA, SB, DR;
    logic [5:0]  A;
    logic [3:0]  alu_op;
    logic        RW, MW, halted, illegal;

    always #5 clk_main = ~clk_main;

    fetch_control dut (
        .clk_main    (clk_main),
        .reset       (reset),
        .PC          (PC),
        .instr_addr  (instr_addr),
        .instr_data  (instr_data),
        .instr_valid (instr_valid),
        .zero        (zero),
        .reg_a_data  (reg_a_data),
        .PS          (PS),
        .SA          (SA),
        .SB          (SB),
        .DR          (DR),
        .A           (A),
        .alu_op      (alu_op),
        .RW          (RW),
        .MW          (MW),
        .halted      (halted),
        .illegal     (illegal)
    );

    typedef struct {
        string       nm;
        logic [1:0]  ps;
        logic        rw;
        logic        mw;
        logic [3:0]  alu;
        logic [5:0]  a;
        logic [5:0]  addr;
        logic [3:0]  dr;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic        hlt;
        logic        ill;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] prev_ir = 16'h0000;
    logic        ill_exp = 1'b0;

    task automatic step();
        @(posedge clk_main);
        #1;
    endtask

    task automatic push(input string nm, input logic [1:0] ps, input logic rw,
                        input logic mw, input logic [3:0] alu, input logic [5:0] a,
                        input logic [15:0] ir, input logic hlt);
        exp_t e;
        e.nm   = nm;
        e.ps   = ps;
        e.rw   = rw;
        e.mw   = mw;
        e.alu  = alu;
        e.a    = a;
        e.addr = PC;
        e.dr   = ir[11:8];
        e.sa   = ir[7:4];
        e.sb   = ir[3:0];
        e.hlt  = hlt;
        e.ill  = ill_exp;
        sb_q.push_back(e);
    endtask

    // One instruction: optional stall cycles, FETCH, DECODE, EXECUTE.
    // zero/reg_a_data carry opposite values outside EXECUTE.
    task automatic run_instr(input string nm, input logic [15:0] d, input logic z,
                             input logic [15:0] ra, input logic [5:0] pc, input int stall,
                             input logic [1:0] eps, input logic erw, input logic emw,
                             input logic [3:0] ealu, input logic [5:0] ea, input logic sets_ill);
        PC         = pc;
        zero       = ~z;
        reg_a_data = ~ra;
        for (int i = 0; i < stall; i++) begin
            instr_valid = 1'b0;
            instr_data  = 16'hF0F0;
            push({nm, "_stall"}, 2'b00, 1'b0, 1'b0, 4'h0, 6'h00, prev_ir, 1'b0);
            step();
        end
        instr_valid = 1'b1;
        instr_data  = d;
        push({nm, "_fetch"}, 2'b00, 1'b0, 1'b0, 4'h0, 6'h00, prev_ir, 1'b0);
        step();
        instr_data  = 16'hFFFF;
        push({nm, "_decode"}, 2'b00, 1'b0, 1'b0, 4'h0, 6'h00, d, 1'b0);
        step();
        zero       = z;
        reg_a_data = ra;
        push({nm, "_exec"}, eps, erw, emw, ealu, ea, d, 1'b0);
        step();
        prev_ir = d;
        if (sets_ill)
            ill_exp = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk_main or posedge reset);
            #1;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (PS !== e.ps || RW !== e.rw || MW !== e.mw || alu_op !== e.alu ||
                    A !== e.a || instr_addr !== e.addr || DR !== e.dr || SA !== e.sa ||
                    SB !== e.sb || halted !== e.hlt || illegal !== e.ill) begin
                    errors++;
                    $display("FAIL %s: got ps=%b rw=%b mw=%b alu=%h a=%h addr=%h dr=%h sa=%h sb=%h halted=%b illegal=%b; want ps=%b rw=%b mw=%b alu=%h a=%h addr=%h dr=%h sa=%h sb=%h halted=%b illegal=%b",
                             e.nm, PS, RW, MW, alu_op, A, instr_addr, DR, SA, SB, halted, illegal,
                             e.ps, e.rw, e.mw, e.alu, e.a, e.addr, e.dr, e.sa, e.sb, e.hlt, e.ill);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        PC          = 6'h15;
        instr_valid = 1'b1;
        instr_data  = 16'hFFFF;
        zero        = 1'b1;
        reg_a_data  = 16'hFFFF;
        reset       = 1'b1;
        step();
        step();
        push("rst_state", 2'b00, 1'b0, 1'b0, 4'h0, 6'h00, 16'h0000, 1'b0);
        step();
        PC = 6'h2A;
        push("rst_pc_follow", 2'b00, 1'b0, 1'b0, 4'h0, 6'h00, 16'h0000, 1'b0);
        step();
        reset = 1'b0;

        run_instr("alu3",      16'h3125, 1'b0, 16'h0000, 6'h00, 0, 2'b01, 1'b1, 1'b0, 4'h3, 6'h00, 1'b0);
        run_instr("brz_taken", 16'hA03F, 1'b1, 16'h0000, 6'h30, 0, 2'b10, 1'b0, 1'b0, 4'h0, 6'h00, 1'b0);
        run_instr("brz_fall",  16'hA03F, 1'b0, 16'h0000, 6'h30, 0, 2'b01, 1'b0, 1'b0, 4'h0, 6'h00, 1'b0);
        run_instr("jmp_2a",    16'hC040, 1'b0, 16'hFF2A, 6'h31, 0, 2'b11, 1'b0, 1'b0, 4'h0, 6'h2A, 1'b0);
        run_instr("jmp_3f",    16'hC040, 1'b1, 16'hFFFF, 6'h2A, 0, 2'b11, 1'b0, 1'b0, 4'h0, 6'h3F, 1'b0);
        run_instr("brnz_stall",16'hB012, 1'b0, 16'h1234, 6'h05, 4, 2'b10, 1'b0, 1'b0, 4'h0, 6'h00, 1'b0);
        run_instr("brnz_fall", 16'hB012, 1'b1, 16'h1234, 6'h06, 0, 2'b01, 1'b0, 1'b0, 4'h0, 6'h00, 1'b0);
        run_instr("ld",        16'h8345, 1'b0, 16'h0000, 6'h07, 0, 2'b01, 1'b1, 1'b0, 4'h0, 6'h00, 1'b0);
        run_instr("st",        16'h9678, 1'b1, 16'h0000, 6'h08, 0, 2'b01, 1'b0, 1'b1, 4'h0, 6'h00, 1'b0);
        run_instr("alu7",      16'h7ABC, 1'b0, 16'h0000, 6'h09, 1, 2'b01, 1'b1, 1'b0, 4'h7, 6'h00, 1'b0);
        run_instr("nop",       16'h0000, 1'b1, 16'h0000, 6'h0A, 0, 2'b01, 1'b0, 1'b0, 4'h0, 6'h00, 1'b0);
        run_instr("ill_e",     16'hE123, 1'b0, 16'h0000, 6'h0B, 0, 2'b01, 1'b0, 1'b0, 4'h0, 6'h00, 1'b1);
        run_instr("ill_d",     16'hD456, 1'b1, 16'h0000, 6'h0C, 0, 2'b01, 1'b0, 1'b0, 4'h0, 6'h00, 1'b1);
        run_instr("alu1",      16'h1111, 1'b0, 16'h0000, 6'h0D, 0, 2'b01, 1'b1, 1'b0, 4'h1, 6'h00, 1'b0);
        run_instr("halt",      16'hF000, 1'b1, 16'h0000, 6'h0E, 0, 2'b00, 1'b0, 1'b0, 4'h0, 6'h00, 1'b0);

        for (int i = 0; i < 12; i++) begin
            instr_valid = 1'b1;
            instr_data  = 16'h3125;
            PC          = 6'(i);
            push("halted", 2'b00, 1'b0, 1'b0, 4'h0, 6'h00, 16'hF000, 1'b1);
            step();
        end

        ill_exp = 1'b0;
        prev_ir = 16'h0000;
        reset   = 1'b1;
        push("rst_from_halt", 2'b00, 1'b0, 1'b0, 4'h0, 6'h00, 16'h0000, 1'b0);
        step();
        reset = 1'b0;

        run_instr("ill_pre_st", 16'hD000, 1'b0, 16'h0000, 6'h10, 0, 2'b01, 1'b0, 1'b0, 4'h0, 6'h00, 1'b1);

        PC          = 6'h11;
        instr_valid = 1'b1;
        instr_data  = 16'h9000;
        push("st_async_fetch", 2'b00, 1'b0, 1'b0, 4'h0, 6'h00, prev_ir, 1'b0);
        step();
        instr_valid = 1'b0;
        push("st_async_decode", 2'b00, 1'b0, 1'b0, 4'h0, 6'h00, 16'h9000, 1'b0);
        step();
        push("st_async_exec", 2'b01, 1'b0, 1'b1, 4'h0, 6'h00, 16'h9000, 1'b0);
        @(negedge clk_main);
        #2;
        ill_exp = 1'b0;
        prev_ir = 16'h0000;
        push("async_rst", 2'b00, 1'b0, 1'b0, 4'h0, 6'h00, 16'h0000, 1'b0);
        reset = 1'b1;
        step();
        instr_valid = 1'b1;
        instr_data  = 16'h9ABC;
        push("rst_hold", 2'b00, 1'b0, 1'b0, 4'h0, 6'h00, 16'h0000, 1'b0);
        step();
        reset = 1'b0;

        run_instr("post_rst", 16'h2345, 1'b0, 16'h0000, 6'h12, 0, 2'b01, 1'b1, 1'b0, 4'h2, 6'h00, 1'b0);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++)
            @(negedge clk_main);
        #2;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations pending, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 clk_main  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 PC  in  6  current program-counter value.
REQ-004 instr_addr  out  6  instruction-memory address.
REQ-005 instr_data  in  16  instruction word; fields opcode[15:12], DR[11:8], SA[7:4], SB[3:0].
REQ-006 instr_valid  in  1  memory handshake; instr_data is valid this cycle.
REQ-007 zero  in  1  ALU zero flag for the register addressed by SA.
REQ-008 reg_a_data  in  16  register-file read data for SA; jump source.
REQ-009 PS  out  2  PC select: 00 hold, 01 increment, 10 branch, 11 jump.
REQ-010 SA, SB, DR  out  4 each  register-field outputs taken from the instruction register (IR).
REQ-011 A  out  6  jump target.
REQ-012 alu_op  out  4  ALU function.
REQ-013 RW  out  1  register-write strobe.
REQ-014 MW  out  1  memory-write strobe.
REQ-015 halted  out  1  high while in HALT.
REQ-016 illegal  out  1  sticky flag: an undefined opcode was executed.

Function
REQ-017 FSM states SHALL be FETCH, DECODE, EXECUTE and HALT.
REQ-018 FETCH: instr_addr=PC and PS=00; on instr_valid=1, latch IR<=instr_data and go to DECODE; otherwise stay in FETCH indefinitely.
REQ-019 DECODE: one cycle, PS=00, RW=MW=0; then go to EXECUTE.
REQ-020 EXECUTE: one cycle; strobes and PS are driven per opcode; then go to FETCH, or to HALT for opcode 0xF.
REQ-021 Opcode 0x0 NOP: PS=01.
REQ-022 Opcodes 0x1-0x7: alu_op=opcode, RW=1, PS=01.
REQ-023 Opcode 0x8 LD: RW=1, PS=01.
REQ-024 Opcode 0x9 ST: MW=1, PS=01.
REQ-025 Opcode 0xA BRZ: PS=10 if zero=1, else PS=01.
REQ-026 Opcode 0xB BRNZ: PS=10 if zero=0, else PS=01.
REQ-027 Opcode 0xC JMP: PS=11 and A=reg_a_data[5:0]; bits [15:6] are ignored.
REQ-028 Opcode 0xF HALT: PS=00.
REQ-029 Opcodes 0xD and 0xE: execute as NOP (PS=01) and set illegal=1; illegal stays set until reset.
REQ-030 RW, MW and a non-zero PS SHALL be asserted only in EXECUTE, for exactly one cycle per instruction.
REQ-031 Branch target arithmetic (PC+{SA[1:0],SB}+1) is modulo 64; fetch_control does not check for wrap.
REQ-032 zero and reg_a_data are sampled combinationally during EXECUTE only.
REQ-033 Minimum instruction time is 3 cycles (instr_valid high on first FETCH cycle); each FETCH cycle with instr_valid=0 adds one cycle.
REQ-034 HALT: PS=00, RW=MW=0, halted=1; the state is left only by reset.
REQ-035 A=0 and alu_op=0 outside EXECUTE.

Reset
REQ-036 While reset=1, regardless of clock: state=FETCH, IR=0, illegal=0, and all outputs 0 except instr_addr, which follows PC.
REQ-037 Reset asserted mid-instruction aborts the instruction with no RW/MW strobe; fetch restarts on the first clk_main edge after release.

Structure
REQ-038 A shared package fetch_ctrl_pkg SHALL hold the opcode constants, the PS encodings and the state encoding.
REQ-039 One combinational sub-module, fetch_decode, SHALL map {opcode, zero} to {PS, RW, MW, alu_op, illegal_op}; the FSM, IR and sticky flag stay in fetch_control.

Verification
REQ-040 Reset, then IR=0x3125 with instr_valid=1 in FETCH -> EXECUTE on cycle 3 with alu_op=3, RW=1, PS=01, DR=1, SA=2, SB=5.
REQ-041 BRZ 0xA03F with zero=1 at PC=0x30 -> PS=10 for one cycle; together with the program counter, next PC=0x30 (0x30+0x3F+1 mod 64).
REQ-042 JMP 0xC040 with reg_a_data=0xFF2A -> PS=11, A=0x2A; JMP with reg_a_data=0xFFFF -> A=0x3F.
REQ-043 instr_valid held low for 4 cycles in FETCH -> PS=00, RW=MW=0 throughout; instruction completes 4 cycles late.
REQ-044 Opcode 0xE -> PS=01 and illegal=1, which persists across later instructions; 0xF000 -> halted=1 and PS=00 for 10+ cycles, ignoring instr_valid.
REQ-045 reset pulsed asynchronously (between clock edges) during EXECUTE of ST 0x9000 -> MW drops immediately and all state/outputs reach reset values per REQ-036.
